tremolo_modulator: RTL

TREMOLO_MODULATOR -- requirements
Module: tremolo_modulator

---
 rtl/tremolo_modulator.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/tremolo_modulator.sv
// Tremolo modulator: start/stop control of an external triangle LFO plus a
// fixed-latency gain pipeline that scales audio samples by the LFO-derived gain.
module tremolo_modulator (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic [1:0]  i_freq,
  input  logic [1:0]  i_depth,
  input  logic        i_valid,
  input  logic [15:0] i_sample,
  input  logic [15:0] i_tri,
  output logic        o_lfo_start,
  output logic        o_lfo_stop,
  output logic [1:0]  o_lfo_freq,
  output logic        o_valid,
  output logic [15:0] o_sample
);

  localparam int unsigned SW = 16;
  localparam int unsigned GW = 15;
  localparam int unsigned PW = 32;
  localparam int unsigned DW = 2;
  localparam int unsigned FW = 2;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [DW-1:0]  depth_q, depth_d;
  logic [FW-1:0]  freq_q, freq_d;
  logic           start_q, start_d;
  logic           stop_q, stop_d;
  logic [DW-1:0]  eff_depth;

  logic                 s1_valid_q;
  logic signed [SW-1:0] s1_sample_q;
  logic [SW-1:0]        s1_tri_q;
  logic [DW-1:0]        s1_depth_q;

  logic [SW-1:0]        tri_off;
  logic [GW-1:0]        lfo, att, satt, gain;

  logic                 s2_valid_q;
  logic signed [SW-1:0] s2_sample_q;
  logic [GW-1:0]        s2_gain_q;
  logic                 s2_bypass_q;

  logic signed [PW-1:0] prod;
  logic [SW-1:0]        out_sample_d;
  logic                 out_valid_q;
  logic [SW-1:0]        out_sample_q;
  logic                 calc_unused;

  // Control state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state: stop dominates start; start only honoured when idle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start && !i_stop) state_d = S_RUN;
      S_RUN:   if (i_stop)             state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control outputs: latch settings and form one-cycle LFO pulses
  always_comb begin
    depth_d = depth_q;
    freq_d  = freq_q;
    start_d = 1'b0;
    stop_d  = 1'b0;
    if (state_q == S_IDLE && i_start && !i_stop) begin
      depth_d = i_depth;
      freq_d  = i_freq;
      start_d = 1'b1;
    end
    if (state_q == S_RUN && i_stop) stop_d = 1'b1;
  end

  // Registered control outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      depth_q <= '0;
      freq_q  <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      depth_q <= depth_d;
      freq_q  <= freq_d;
      start_q <= start_d;
      stop_q  <= stop_d;
    end
  end

  assign eff_depth = (state_q == S_RUN) ? depth_q : DW'(0);

  // Stage 1: capture sample, LFO value and the depth in force right now
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sample_q <= '0;
      s1_tri_q    <= '0;
      s1_depth_q  <= '0;
    end else begin
      s1_valid_q <= i_valid;
      if (i_valid) begin
        s1_sample_q <= $signed(i_sample);
        s1_tri_q    <= i_tri;
        s1_depth_q  <= eff_depth;
      end
    end
  end

  // Gain from LFO: offset-binary conversion, attenuation scaled by depth
  always_comb begin
    tri_off = s1_tri_q ^ 16'h8000;
    lfo     = tri_off[SW-1:1];
    att     = GW'(15'h7FFF - lfo);
    case (s1_depth_q)
      2'd1:    satt = att >> 2;
      2'd2:    satt = att >> 1;
      default: satt = att;
    endcase
    gain = GW'(15'h7FFF - satt);
  end

  // Stage 2: hold sample with its gain and bypass flag
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s2_valid_q  <= 1'b0;
      s2_sample_q <= '0;
      s2_gain_q   <= '0;
      s2_bypass_q <= 1'b0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_sample_q <= s1_sample_q;
        s2_gain_q   <= gain;
        s2_bypass_q <= (s1_depth_q == DW'(0));
      end
    end
  end

  // Signed product with zero-extended gain, rescaled by 2^-15 (floor)
  always_comb begin
    prod         = PW'(s2_sample_q) * PW'($signed({1'b0, s2_gain_q}));
    out_sample_d = s2_bypass_q ? s2_sample_q : prod[30:15];
    calc_unused  = ^{prod[31], prod[14:0], tri_off[0]};
  end

  // Output register: sample held while no new result arrives
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
    end else begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) out_sample_q <= out_sample_d;
    end
  end

  assign o_lfo_start = start_q;
  assign o_lfo_stop  = stop_q;
  assign o_lfo_freq  = freq_q;
  assign o_valid     = out_valid_q;
  assign o_sample    = out_sample_q;

endmodule
